// File: rtl/execute_stage_if.sv
// EX-stage handshake bundle: upstream instruction/operand bus, flag controls, EX/MEM output bus.
// Upstream and downstream both drive through the master side; the execute stage uses the slave side.
interface execute_stage_if #(
   parameter int WIDTH  = 16,
   parameter int DEST_W = 3
);
   logic              inValid;
   logic              inReady;
   logic              aluEn;
   logic [2:0]        func;
   logic [WIDTH-1:0]  readData1;
   logic [WIDTH-1:0]  readData2;
   logic [DEST_W-1:0] destIn;
   logic              flagWrEn;
   logic              flagSetC;
   logic              flagClrC;
   logic              flagRestore;
   logic [2:0]        flagRestoreVal;
   logic              outValid;
   logic              outReady;
   logic [WIDTH-1:0]  aluResult;
   logic [DEST_W-1:0] destOut;
   logic [2:0]        flag;

   modport master (
      output inValid, aluEn, func, readData1, readData2, destIn,
             flagWrEn, flagSetC, flagClrC, flagRestore, flagRestoreVal, outReady,
      input  inReady, outValid, aluResult, destOut, flag
   );

   modport slave (
      input  inValid, aluEn, func, readData1, readData2, destIn,
             flagWrEn, flagSetC, flagClrC, flagRestore, flagRestoreVal, outReady,
      output inReady, outValid, aluResult, destOut, flag
   );
endinterface

// File: rtl/execute_stage.sv
// Registered execute stage: ALU, {C,N,Z} flag register and valid/ready EX/MEM output.
// Define EXECUTE_MUL_EN to turn func 111 from INC into a WIDTH-cycle shift-add multiply.
module execute_stage #(
   parameter int WIDTH   = 16,
   parameter int DEST_W  = 3,
   parameter int SHAMT_W = 4
) (
   input logic            clk,
   input logic            rst_n,
   execute_stage_if.slave ex
);
   // state | meaning
   // IDLE  | accepting instructions (the only state without EXECUTE_MUL_EN)
   // MUL   | shift-add iterations, one multiplier bit per cycle
   // DONE  | product ready, loaded once the output register is free
`ifdef EXECUTE_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`else
   typedef enum logic [0:0] {IDLE} state_t;
`endif

   state_t            state_q, state_d;
   logic              in_ready, accept, is_mul;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  alu_result_q, alu_result_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [2:0]        flag_q, flag_d;
   logic [WIDTH-1:0]  alu_res;
   logic [WIDTH:0]    sum;
   logic [2*WIDTH-1:0] shl_ext;
   logic [SHAMT_W-1:0] shamt;
   logic              c_new, c_valid;

`ifdef EXECUTE_MUL_EN
   logic                 mul_finish;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mul_acc_q, mul_acc_d, mul_mcand_q, mul_mcand_d;
   logic [WIDTH-1:0]     mul_mplier_q, mul_mplier_d;
   logic [DEST_W-1:0]    mul_dest_q, mul_dest_d;
   logic [3:0]           mul_ctl_q, mul_ctl_d;
   logic [2:0]           mul_rv_q, mul_rv_d;
`endif

   function automatic logic [2:0] next_flags(input logic [2:0] cur, input logic [WIDTH-1:0] res,
                                             input logic c_in, c_ok, wr, setc, clrc, rest,
                                             input logic [2:0] rv);
      logic [2:0] f;
      f = cur;
      if (rest) begin
         f = rv;
      end else begin
         if (wr) begin
            f[0] = (res == '0);
            f[1] = res[WIDTH-1];
            if (c_ok) f[2] = c_in;
         end
         if (clrc)      f[2] = 1'b0;
         else if (setc) f[2] = 1'b1;
      end
      return f;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
`ifdef EXECUTE_MUL_EN
      unique case (state_q)
         IDLE:    if (accept && is_mul) state_d = MUL;
         MUL:     if (cnt_q == '0) state_d = DONE;
         DONE:    if (mul_finish) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`endif
   end

   always_comb begin
      in_ready = (state_q == IDLE) && (!out_valid_q || ex.outReady);
`ifdef EXECUTE_MUL_EN
      // a finished product waits in DONE rather than overwrite an undrained result
      mul_finish = (state_q == DONE) && (!out_valid_q || ex.outReady);
`endif
   end

`ifdef EXECUTE_MUL_EN
   assign is_mul = ex.aluEn && (ex.func == 3'b111);
`else
   assign is_mul = 1'b0;
`endif
   assign accept = ex.inValid && in_ready;

   always_comb begin
      alu_res = ex.readData2;
      sum     = '0;
      shl_ext = '0;
      shamt   = ex.readData2[SHAMT_W-1:0];
      c_new   = 1'b0;
      c_valid = 1'b0;
      if (ex.aluEn) begin
         unique case (ex.func)
            3'b000: alu_res = ex.readData1;
            3'b001: alu_res = ~ex.readData1;
            3'b010: begin
               sum = {1'b0, ex.readData1} + {1'b0, ex.readData2};
               alu_res = sum[WIDTH-1:0]; c_new = sum[WIDTH]; c_valid = 1'b1;
            end
            3'b011: begin
               sum = {1'b0, ex.readData1} - {1'b0, ex.readData2};
               alu_res = sum[WIDTH-1:0]; c_new = sum[WIDTH]; c_valid = 1'b1;
            end
            3'b100: alu_res = ex.readData1 & ex.readData2;
            3'b101: alu_res = ex.readData1 | ex.readData2;
            3'b110: begin
               shl_ext = {{WIDTH{1'b0}}, ex.readData1} << shamt;
               alu_res = shl_ext[WIDTH-1:0]; c_new = shl_ext[WIDTH]; c_valid = (shamt != '0);
            end
            default: begin
`ifdef EXECUTE_MUL_EN
               alu_res = '0;
`else
               sum = {1'b0, ex.readData1} + (WIDTH+1)'(1);
               alu_res = sum[WIDTH-1:0]; c_new = sum[WIDTH]; c_valid = 1'b1;
`endif
            end
         endcase
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      alu_result_d = alu_result_q;
      dest_d       = dest_q;
      flag_d       = flag_q;
      if (accept && !is_mul) begin
         out_valid_d  = 1'b1;
         alu_result_d = alu_res;
         dest_d       = ex.destIn;
         flag_d       = next_flags(flag_q, alu_res, c_new, c_valid, ex.flagWrEn && ex.aluEn,
                                   ex.flagSetC, ex.flagClrC, ex.flagRestore, ex.flagRestoreVal);
      end
`ifdef EXECUTE_MUL_EN
      else if (mul_finish) begin
         out_valid_d  = 1'b1;
         alu_result_d = mul_acc_q[WIDTH-1:0];
         dest_d       = mul_dest_q;
         flag_d       = next_flags(flag_q, mul_acc_q[WIDTH-1:0], |mul_acc_q[2*WIDTH-1:WIDTH], 1'b1,
                                   mul_ctl_q[3], mul_ctl_q[2], mul_ctl_q[1], mul_ctl_q[0], mul_rv_q);
      end
`endif
      else if (out_valid_q && ex.outReady) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         alu_result_q <= '0;
         dest_q       <= '0;
         flag_q       <= 3'b000;
      end else begin
         out_valid_q  <= out_valid_d;
         alu_result_q <= alu_result_d;
         dest_q       <= dest_d;
         flag_q       <= flag_d;
      end
   end

`ifdef EXECUTE_MUL_EN
   always_comb begin
      cnt_d        = cnt_q;
      mul_acc_d    = mul_acc_q;
      mul_mcand_d  = mul_mcand_q;
      mul_mplier_d = mul_mplier_q;
      mul_dest_d   = mul_dest_q;
      mul_ctl_d    = mul_ctl_q;
      mul_rv_d     = mul_rv_q;
      if (accept && is_mul) begin
         cnt_d        = CNT_W'(WIDTH - 1);
         mul_acc_d    = '0;
         mul_mcand_d  = {{WIDTH{1'b0}}, ex.readData1};
         mul_mplier_d = ex.readData2;
         mul_dest_d   = ex.destIn;
         mul_ctl_d    = {ex.flagWrEn, ex.flagSetC, ex.flagClrC, ex.flagRestore};
         mul_rv_d     = ex.flagRestoreVal;
      end else if (state_q == MUL) begin
         if (mul_mplier_q[0]) mul_acc_d = mul_acc_q + mul_mcand_q;
         mul_mcand_d  = mul_mcand_q << 1;
         mul_mplier_d = mul_mplier_q >> 1;
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         mul_acc_q    <= '0;
         mul_mcand_q  <= '0;
         mul_mplier_q <= '0;
         mul_dest_q   <= '0;
         mul_ctl_q    <= '0;
         mul_rv_q     <= '0;
      end else begin
         cnt_q        <= cnt_d;
         mul_acc_q    <= mul_acc_d;
         mul_mcand_q  <= mul_mcand_d;
         mul_mplier_q <= mul_mplier_d;
         mul_dest_q   <= mul_dest_d;
         mul_ctl_q    <= mul_ctl_d;
         mul_rv_q     <= mul_rv_d;
      end
   end
`endif

   assign ex.inReady   = in_ready;
   assign ex.outValid  = out_valid_q;
   assign ex.aluResult = alu_result_q;
   assign ex.destOut   = dest_q;
   assign ex.flag      = flag_q;
endmodule
